// File: rtl/count_sequencer_pkg.sv
// Shared types and default sizing for the count sequencer and its watchdog.
package count_sequencer_pkg;

    localparam int unsigned DEF_ROUND_W = 4;
    localparam int unsigned DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_COUNT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/count_sequencer_watchdog.sv
// Carry watchdog: counts enabled COUNT cycles and flags the cycle that reaches TIMEOUT.
module seq_watchdog
    import count_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at TIMEOUT so a carry that beats the timeout cannot wrap the count.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_W'(TIMEOUT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/count_sequencer.sv
// Sequencer that clears and enables an external counter until a programmed number
// of carries has been collected, with a carry watchdog and abort.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int unsigned ROUND_W = DEF_ROUND_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clkEN,
    input  logic               start,
    input  logic               abort,
    input  logic [ROUND_W-1:0] rounds,
    input  logic               co_in,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ROUND_W-1:0] round_cnt
);

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [ROUND_W-1:0] rounds_q;
    logic [ROUND_W-1:0] round_inc;
    logic               co_q;
    logic               abort_clr_q;
    logic               take_start;
    logic               count_carry;
    logic               abort_go;
    logic               carry_edge;
    logic               wd_clr;
    logic               wd_en;
    logic               wd_term;

    assign carry_edge = co_in && !co_q;
    assign round_inc  = round_cnt + ROUND_W'(1);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .term  (wd_term)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and output decode; abort overrides every other transition.
    always_comb begin
        state_nxt   = state;
        take_start  = 1'b0;
        count_carry = 1'b0;
        abort_go    = 1'b0;
        cnt_en      = 1'b0;
        cnt_clr     = abort_clr_q;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    take_start = 1'b1;
                    state_nxt  = (rounds == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clr   = 1'b1;
                busy      = 1'b1;
                wd_clr    = 1'b1;
                state_nxt = S_COUNT;
            end
            S_COUNT: begin
                cnt_en = clkEN;
                busy   = 1'b1;
                wd_en  = clkEN;
                if (carry_edge) begin
                    count_carry = 1'b1;
                    state_nxt   = (round_inc == rounds_q) ? S_DONE : S_CLEAR;
                end else if (wd_term) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            abort_go    = 1'b1;
            count_carry = 1'b0;
            state_nxt   = S_IDLE;
        end
    end

    // Round bookkeeping, carry history and the post-abort clear pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            rounds_q    <= '0;
            round_cnt   <= '0;
            co_q        <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            co_q        <= co_in;
            abort_clr_q <= abort_go;
            if (take_start) begin
                rounds_q  <= rounds;
                round_cnt <= '0;
            end else if (count_carry) begin
                round_cnt <= round_inc;
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer driving a 3-bit counter model that carries at count 5.
module tb_count_sequencer;
    import count_sequencer_pkg::*;

    localparam int unsigned RW = DEF_ROUND_W;
    localparam int unsigned TO = DEF_TIMEOUT;
    localparam int          CYC_PER_ROUND = 7;
    localparam int          EN_PER_ROUND  = 6;

    logic          clock = 1'b0;
    logic          reset, clkEN, start, abort, co_in;
    logic          cnt_en, cnt_clr, busy, done, err;
    logic [RW-1:0] rounds, round_cnt;
    logic [2:0]    cnt3;
    logic          co_kill;

    int checks = 0;
    int errors = 0;
    int n_clr  = 0;
    int n_done = 0;
    int n_en   = 0;
    int n_bad  = 0;

    always #5 clock = ~clock;

    count_sequencer #(
        .ROUND_W (RW),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clkEN     (clkEN),
        .start     (start),
        .abort     (abort),
        .rounds    (rounds),
        .co_in     (co_in),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .round_cnt (round_cnt)
    );

    // Controlled counter: synchronous clear, count on enable, carry level at 5.
    always @(posedge clock) begin
        if (reset || cnt_clr) cnt3 <= 3'd0;
        else if (cnt_en)      cnt3 <= cnt3 + 3'd1;
    end
    assign co_in = !co_kill && (cnt3 == 3'd5);

    // Event tallies; cnt_en must follow clkEN while counting and stay low otherwise.
    always @(negedge clock) begin
        if (cnt_clr === 1'b1) n_clr++;
        if (done === 1'b1)    n_done++;
        if (cnt_en === 1'b1)  n_en++;
        if ((busy === 1'b1 && cnt_clr === 1'b0) ? (cnt_en !== clkEN) : (cnt_en !== 1'b0)) n_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // pct < 0 toggles clkEN every cycle, otherwise clkEN=1 with probability pct%.
    task automatic drive_en(input int pct);
        if (pct < 0) clkEN = ~clkEN;
        else         clkEN = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
    endtask

    task automatic launch(input int r, input int pct, input bit hold);
        rounds = RW'(r);
        start  = 1'b1;
        drive_en(pct);
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Cycles from the start edge until done or err; -1 if the budget runs out.
    task automatic wait_end(input int pct, input int budget, output int lat, output int jumps);
        logic [RW-1:0] prev;
        lat   = -1;
        jumps = 0;
        prev  = round_cnt;
        for (int i = 0; i < budget; i++) begin
            if (round_cnt !== prev) begin
                if (round_cnt !== prev + RW'(1)) jumps++;
                prev = round_cnt;
            end
            if (done === 1'b1 || err === 1'b1) begin
                lat = i;
                break;
            end
            drive_en(pct);
            tick();
        end
    endtask

    initial begin
        int c0, d0, e0, b0, lat, jmp, r, pct;
        reset = 1'b1; clkEN = 1'b0; start = 1'b0; abort = 1'b0;
        rounds = '0; co_kill = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_cnt_en",    cnt_en,    0);
        check("rst_cnt_clr",   cnt_clr,   0);
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_err",       err,       0);
        check("rst_round_cnt", round_cnt, 0);

        // Two rounds, always enabled.
        c0 = n_clr; d0 = n_done; e0 = n_en; b0 = n_bad;
        launch(2, 100, 1'b0);
        check("r2_busy_after_start", busy, 1);
        wait_end(100, 200, lat, jmp);
        check("r2_latency",   lat,       2 * CYC_PER_ROUND);
        check("r2_round_cnt", round_cnt, 2);
        check("r2_steps",     jmp,       0);
        tick();
        check("r2_clr_pulses", n_clr - c0,  2);
        check("r2_done_pulse", n_done - d0, 1);
        check("r2_en_cycles",  n_en - e0,   2 * EN_PER_ROUND);
        check("r2_en_follow",  n_bad - b0,  0);
        check("r2_busy_end",   busy,        0);
        check("r2_err_end",    err,         0);
        check("r2_done_once",  done,        0);
        check("r2_hold_cnt",   round_cnt,   2);

        // Zero rounds: immediate done, counter untouched.
        c0 = n_clr; e0 = n_en;
        launch(0, 100, 1'b0);
        check("r0_done",      done,      1);
        check("r0_busy",      busy,      0);
        check("r0_round_cnt", round_cnt, 0);
        tick();
        check("r0_clr", n_clr - c0, 0);
        check("r0_en",  n_en - e0,  0);
        check("r0_done_gone", done, 0);

        // Timeout with carries suppressed, full enable then random enable.
        for (int k = 0; k < 2; k++) begin
            pct = (k == 0) ? 100 : 60;
            co_kill = 1'b1;
            e0 = n_en;
            launch(1, pct, 1'b0);
            wait_end(pct, 400, lat, jmp);
            if (k == 0) check("to_latency", lat, TO + 1);
            else        check("to_reached", (lat >= 0) ? 1 : 0, 1);
            check("to_err",       err,       1);
            check("to_en_cycles", n_en - e0, TO);
            clkEN = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            check("err_hold",      err,    1);
            check("err_no_start",  busy,   0);
            check("err_no_cnt_en", cnt_en, 0);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_err_clr", err,     0);
            check("abort_clr",     cnt_clr, 1);
            check("abort_idle",    busy,    0);
            tick();
            check("abort_clr_once", cnt_clr, 0);
            co_kill = 1'b0;
        end

        // Three rounds with clkEN toggling every cycle.
        clkEN = 1'b0;
        c0 = n_clr; d0 = n_done; b0 = n_bad;
        launch(3, -1, 1'b0);
        wait_end(-1, 300, lat, jmp);
        check("tog_done_seen", (lat >= 3 * CYC_PER_ROUND) ? 1 : 0, 1);
        check("tog_round_cnt", round_cnt, 3);
        check("tog_err",       err,       0);
        tick();
        check("tog_clr",    n_clr - c0,  3);
        check("tog_done",   n_done - d0, 1);
        check("tog_follow", n_bad - b0,  0);

        // Abort in round 2 with start held high throughout.
        c0 = n_clr;
        launch(4, 100, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        check("hold_busy",      busy,       1);
        check("hold_round_cnt", round_cnt,  1);
        check("hold_clr",       n_clr - c0, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("mid_abort_busy", busy,    0);
        check("mid_abort_clr",  cnt_clr, 1);
        check("mid_abort_err",  err,     0);
        check("mid_abort_done", done,    0);
        tick();
        check("mid_abort_idle", busy, 0);
        launch(2, 100, 1'b0);
        wait_end(100, 200, lat, jmp);
        check("post_abort_latency",   lat,       2 * CYC_PER_ROUND);
        check("post_abort_round_cnt", round_cnt, 2);
        tick();

        // Reset in round 2 with start held high.
        launch(3, 100, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy",      busy,      0);
        check("mid_rst_clr",       cnt_clr,   0);
        check("mid_rst_cnt_en",    cnt_en,    0);
        check("mid_rst_done",      done,      0);
        check("mid_rst_err",       err,       0);
        check("mid_rst_round_cnt", round_cnt, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        launch(1, 100, 1'b0);
        wait_end(100, 100, lat, jmp);
        check("post_rst_latency",   lat,       CYC_PER_ROUND);
        check("post_rst_round_cnt", round_cnt, 1);
        tick();

        // Random round counts and enable densities against the per-round arithmetic.
        for (int k = 0; k < 8; k++) begin
            r   = int'($urandom_range((1 << RW) - 1));
            pct = (k % 3 == 0) ? 100 : int'($urandom_range(100, 30));
            c0 = n_clr; d0 = n_done; b0 = n_bad;
            launch(r, pct, 1'b0);
            wait_end(pct, 2000, lat, jmp);
            if (pct == 100) check("rnd_latency", lat, r * CYC_PER_ROUND);
            else            check("rnd_latency_min", (lat >= r * CYC_PER_ROUND) ? 1 : 0, 1);
            check("rnd_round_cnt", round_cnt, r);
            check("rnd_steps",     jmp,       0);
            check("rnd_err",       err,       0);
            tick();
            check("rnd_clr",    n_clr - c0,  r);
            check("rnd_done",   n_done - d0, 1);
            check("rnd_follow", n_bad - b0,  0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
